// File: rtl/instr_split_stage_pkg.sv
// instr_split_stage_pkg: shared opcodes, extender-op codes and stage storage types
// Package instr_pkg: no ports. Provides OP_* opcode values, EOP_* extender
// opcodes, fields_t (instruction split into MIPS fields), entry_t (one
// decoded instruction as held by the stage) and state_t (skid-buffer fill state).
package instr_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [1:0] EOP_SIGN = 2'd0;
   localparam logic [1:0] EOP_ZERO = 2'd1;
   localparam logic [1:0] EOP_LUI  = 2'd2;
   localparam logic [1:0] EOP_BR   = 2'd3;

   typedef struct packed {
      logic [5:0] op;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] rd;
      logic [4:0] shamt;
      logic [5:0] funct;
   } fields_t;

   typedef struct packed {
      fields_t     f;
      logic [31:0] pc;
      logic [1:0]  eop;
      logic        illegal;
   } entry_t;

   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

endpackage

// File: rtl/instr_split_stage_if.sv
// instr_split_stage_if: fetch-side and extender-side handshake bundle of the split stage
// Input side : in_valid, in_ready, in_instr[31:0], in_pc[31:0]
// Output side: out_valid, out_ready, out_pc, out_op, out_rs, out_rt, out_rd,
//              out_shamt, out_funct, out_imm, out_index, out_eop, out_illegal
// slave  = the stage itself, master = the surrounding fetch/extender logic.
interface instr_split_stage_if;

   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [5:0]  out_op;
   logic [4:0]  out_rs;
   logic [4:0]  out_rt;
   logic [4:0]  out_rd;
   logic [4:0]  out_shamt;
   logic [5:0]  out_funct;
   logic [15:0] out_imm;
   logic [25:0] out_index;
   logic [1:0]  out_eop;
   logic        out_illegal;

   modport master (
      output in_valid, in_instr, in_pc, out_ready,
      input  in_ready, out_valid, out_pc, out_op, out_rs, out_rt, out_rd,
             out_shamt, out_funct, out_imm, out_index, out_eop, out_illegal
   );

   modport slave (
      input  in_valid, in_instr, in_pc, out_ready,
      output in_ready, out_valid, out_pc, out_op, out_rs, out_rt, out_rd,
             out_shamt, out_funct, out_imm, out_index, out_eop, out_illegal
   );

endinterface

// File: rtl/instr_split_stage_eop_decode.sv
// eop_decode: maps a primary opcode to the immediate extender opcode and a legality flag
// op[5:0]  : primary opcode (instr[31:26])
// eop[1:0] : extender opcode (sign / zero / lui / branch)
// illegal  : opcode outside the supported set (eop forced to sign-extend)
module eop_decode
   import instr_pkg::*;
(
   input  logic [5:0] op,
   output logic [1:0] eop,
   output logic       illegal
);

   always_comb begin
      eop     = EOP_SIGN;
      illegal = 1'b0;
      case (op)
         OP_RTYPE, OP_ADDI, OP_ADDIU, OP_LW, OP_SW, OP_J, OP_JAL: eop = EOP_SIGN;
         OP_ANDI, OP_ORI, OP_XORI:                                eop = EOP_ZERO;
         OP_LUI:                                                  eop = EOP_LUI;
         OP_BEQ, OP_BNE:                                          eop = EOP_BR;
         default:                                                 illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/instr_split_stage.sv
// instr_split_stage: registered fetch-to-extender decode stage with optional two-entry skid buffer
// clk   : rising-edge clock
// reset : asynchronous active-low reset, drops every held word
// flush : synchronous discard of all held words (and of a word offered that cycle)
// bus   : slave side of instr_split_stage_if (input words, decoded output fields)
// SKID  : 1 = main + skid register with registered in_ready, 0 = single register
module instr_split_stage
   import instr_pkg::*;
#(
   parameter bit SKID = 1'b1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush,
   instr_split_stage_if.slave   bus
);

   logic [1:0] in_eop;
   logic       in_ill;
   entry_t     in_e;
   entry_t     m_q;
   logic       in_xfer;
   logic       out_xfer;

   // decode on entry so the held state already carries eop/illegal
   eop_decode u_dec (
      .op      (bus.in_instr[31:26]),
      .eop     (in_eop),
      .illegal (in_ill)
   );

   assign in_e     = {bus.in_instr, bus.in_pc, in_eop, in_ill};
   assign in_xfer  = bus.in_valid && bus.in_ready;
   assign out_xfer = bus.out_valid && bus.out_ready;

   generate
      if (SKID) begin : g_skid
         state_t state_q, state_d;
         entry_t m_d, s_q, s_d;
         logic   in_ready_q, in_ready_d;
         logic   out_valid_q, out_valid_d;
         always_comb begin
            state_d = state_q;
            m_d     = m_q;
            s_d     = s_q;
            case (state_q)
               EMPTY: begin
                  if (in_xfer) begin
                     m_d     = in_e;
                     state_d = ONE;
                  end
               end
               ONE: begin
                  if (in_xfer && !out_xfer) begin
                     s_d     = in_e;
                     state_d = TWO;
                  end else if (in_xfer) begin
                     m_d = in_e;
                  end else if (out_xfer) begin
                     state_d = EMPTY;
                  end
               end
               TWO: begin
                  if (out_xfer) begin
                     m_d     = s_q;
                     state_d = ONE;
                  end
               end
               default: state_d = EMPTY;
            endcase
            if (flush) state_d = EMPTY;
            in_ready_d  = state_d != TWO;
            out_valid_d = state_d != EMPTY;
         end
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               state_q     <= EMPTY;
               m_q         <= '0;
               s_q         <= '0;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end else begin
               state_q     <= state_d;
               m_q         <= m_d;
               s_q         <= s_d;
               in_ready_q  <= in_ready_d;
               out_valid_q <= out_valid_d;
            end
         end
         assign bus.in_ready  = in_ready_q;
         assign bus.out_valid = out_valid_q;
      end else begin : g_reg
         logic   v_q, v_d;
         entry_t m_d;
         always_comb begin
            v_d = flush ? 1'b0 : in_xfer ? 1'b1 : out_xfer ? 1'b0 : v_q;
            m_d = (in_xfer && !flush) ? in_e : m_q;
         end
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               v_q <= 1'b0;
               m_q <= '0;
            end else begin
               v_q <= v_d;
               m_q <= m_d;
            end
         end
         // single register: free when empty or being drained this cycle
         assign bus.in_ready  = !v_q || bus.out_ready;
         assign bus.out_valid = v_q;
      end
   endgenerate

   assign bus.out_pc      = m_q.pc;
   assign bus.out_op      = m_q.f.op;
   assign bus.out_rs      = m_q.f.rs;
   assign bus.out_rt      = m_q.f.rt;
   assign bus.out_rd      = m_q.f.rd;
   assign bus.out_shamt   = m_q.f.shamt;
   assign bus.out_funct   = m_q.f.funct;
   assign bus.out_imm     = {m_q.f.rd, m_q.f.shamt, m_q.f.funct};
   assign bus.out_index   = {m_q.f.rs, m_q.f.rt, m_q.f.rd, m_q.f.shamt, m_q.f.funct};
   assign bus.out_eop     = m_q.eop;
   assign bus.out_illegal = m_q.illegal;

endmodule

// File: tb/tb_instr_split_stage.sv
// tb_instr_split_stage: checks SKID=1 and SKID=0 builds against a queue-based reference model
module tb_instr_split_stage;

   typedef struct packed {
      logic [31:0] pc;
      logic [5:0]  op;
      logic [4:0]  rs, rt, rd, sh;
      logic [5:0]  fn;
      logic [15:0] imm;
      logic [25:0] idx;
      logic [1:0]  eop;
      logic        ill;
   } fld_t;

   typedef struct packed {
      logic rdy;
      logic vld;
      fld_t f;
   } obs_t;

   typedef struct {
      logic [31:0] w;
      logic [31:0] pc;
   } wp_t;

   typedef struct {
      logic [31:0] w;
      logic [5:0]  op;
      logic [4:0]  rs, rt, rd, sh;
      logic [5:0]  fn;
      logic [15:0] imm;
      logic [25:0] idx;
      logic [1:0]  eop;
      logic        ill;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0;
   logic in_valid = 1'b0;
   logic out_ready = 1'b0;
   logic [31:0] in_instr = '0;
   logic [31:0] in_pc = '0;
   int n_cmp = 0;
   int n_bad = 0;
   wp_t qa[$];
   wp_t qb[$];
   obs_t oa, ob;

   always #5 clk = ~clk;

   instr_split_stage_if ia ();
   instr_split_stage_if ib ();

   assign ia.in_valid = in_valid;
   assign ia.in_instr = in_instr;
   assign ia.in_pc = in_pc;
   assign ia.out_ready = out_ready;
   assign ib.in_valid = in_valid;
   assign ib.in_instr = in_instr;
   assign ib.in_pc = in_pc;
   assign ib.out_ready = out_ready;

   assign oa = {ia.in_ready, ia.out_valid, ia.out_pc, ia.out_op, ia.out_rs, ia.out_rt, ia.out_rd,
                ia.out_shamt, ia.out_funct, ia.out_imm, ia.out_index, ia.out_eop, ia.out_illegal};
   assign ob = {ib.in_ready, ib.out_valid, ib.out_pc, ib.out_op, ib.out_rs, ib.out_rt, ib.out_rd,
                ib.out_shamt, ib.out_funct, ib.out_imm, ib.out_index, ib.out_eop, ib.out_illegal};

   instr_split_stage #(.SKID(1'b1)) dut_a (.clk(clk), .reset(rst_n), .flush(flush), .bus(ia));
   instr_split_stage #(.SKID(1'b0)) dut_b (.clk(clk), .reset(rst_n), .flush(flush), .bus(ib));

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // {illegal, eop} straight from the supported-opcode table
   function automatic logic [2:0] ref_dec(input logic [5:0] op);
      if (op inside {6'h00, 6'h08, 6'h09, 6'h23, 6'h2B, 6'h02, 6'h03}) return 3'b0_00;
      if (op inside {6'h0C, 6'h0D, 6'h0E}) return 3'b0_01;
      if (op == 6'h0F) return 3'b0_10;
      if (op inside {6'h04, 6'h05}) return 3'b0_11;
      return 3'b1_00;
   endfunction

   function automatic fld_t exp_f(input wp_t x);
      fld_t f;
      f.pc = x.pc;
      f.op = x.w[31:26];
      f.rs = x.w[25:21];
      f.rt = x.w[20:16];
      f.rd = x.w[15:11];
      f.sh = x.w[10:6];
      f.fn = x.w[5:0];
      f.imm = x.w[15:0];
      f.idx = x.w[25:0];
      {f.ill, f.eop} = ref_dec(x.w[31:26]);
      return f;
   endfunction

   task automatic check_side(input string tag, input obs_t o, input bit rdy, input bit vld, input wp_t fr);
      chk({tag, "_in_ready"}, 128'(o.rdy), 128'(rdy));
      chk({tag, "_out_valid"}, 128'(o.vld), 128'(vld));
      if (vld) chk({tag, "_fields"}, 128'(o.f), 128'(exp_f(fr)));
   endtask

   // one clock: compare both DUTs with the model, then advance the model at the edge
   task automatic cycle();
      bit ra, rb, va, vb;
      wp_t fa, fb, nw;
      #1;
      ra = qa.size() < 2;
      rb = qb.size() == 0 || out_ready;
      va = qa.size() > 0;
      vb = qb.size() > 0;
      fa = va ? qa[0] : '{w: 0, pc: 0};
      fb = vb ? qb[0] : '{w: 0, pc: 0};
      check_side("a", oa, ra, va, fa);
      check_side("b", ob, rb, vb, fb);
      nw = '{w: in_instr, pc: in_pc};
      @(posedge clk);
      if (flush) begin
         qa.delete();
         qb.delete();
      end else begin
         if (va && out_ready) void'(qa.pop_front());
         if (vb && out_ready) void'(qb.pop_front());
         if (in_valid && ra) qa.push_back(nw);
         if (in_valid && rb) qb.push_back(nw);
      end
      #1;
   endtask

   function automatic logic [31:0] rand_word();
      logic [5:0] ops [13] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09,
                               6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};
      logic [31:0] r;
      logic [5:0] op;
      r = $urandom();
      op = ($urandom_range(0, 3) == 0) ? 6'($urandom()) : ops[$urandom_range(0, 12)];
      return {op, r[25:0]};
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vt[8];
      fld_t ef;
      obs_t z;
      vt[0] = '{32'h00221820, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h1820, 26'h0221820, 2'd0, 1'b0};
      vt[1] = '{32'h3C01F3D4, 6'h0F, 5'd0, 5'd1, 5'd30, 5'd15, 6'h14, 16'hF3D4, 26'h001F3D4, 2'd2, 1'b0};
      vt[2] = '{32'h3422F3D4, 6'h0D, 5'd1, 5'd2, 5'd30, 5'd15, 6'h14, 16'hF3D4, 26'h022F3D4, 2'd1, 1'b0};
      vt[3] = '{32'h1022FFFE, 6'h04, 5'd1, 5'd2, 5'd31, 5'd31, 6'h3E, 16'hFFFE, 26'h022FFFE, 2'd3, 1'b0};
      vt[4] = '{32'hFC000000, 6'h3F, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0000, 26'h0000000, 2'd0, 1'b1};
      vt[5] = '{32'h8C430004, 6'h23, 5'd2, 5'd3, 5'd0, 5'd0, 6'h04, 16'h0004, 26'h0430004, 2'd0, 1'b0};
      vt[6] = '{32'h08000010, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h10, 16'h0010, 26'h0000010, 2'd0, 1'b0};
      vt[7] = '{32'h18000000, 6'h06, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0000, 26'h0000000, 2'd0, 1'b1};
      z = '0;
      z.rdy = 1'b1;

      #12;
      chk("reset_a", 128'(oa), 128'(z));
      chk("reset_b", 128'(ob), 128'(z));
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // field / eop decode table, streaming through with out_ready high
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         in_instr = vt[i].w;
         in_pc = 32'h1000 + 32'(i * 4);
         cycle();
         ef = {in_pc, vt[i].op, vt[i].rs, vt[i].rt, vt[i].rd, vt[i].sh, vt[i].fn,
               vt[i].imm, vt[i].idx, vt[i].eop, vt[i].ill};
         chk($sformatf("vec%0d_a", i), 128'(oa.f), 128'(ef));
         chk($sformatf("vec%0d_b", i), 128'(ob.f), 128'(ef));
      end
      in_valid = 1'b0;
      repeat (3) cycle();

      // backpressure: A fills both entries, third word waits upstream
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_pc = 32'h3000;
      in_instr = 32'h20000000 | in_pc;
      cycle();
      chk("bp_a_pc0", 128'(oa.f.pc), 128'h3000);
      chk("bp_b_rdy_stall", 128'(ob.rdy), 128'd0);
      in_pc = 32'h3004;
      in_instr = 32'h20000000 | in_pc;
      cycle();
      chk("bp_a_rdy_two", 128'(oa.rdy), 128'd0);
      chk("bp_a_pc1", 128'(oa.f.pc), 128'h3000);
      in_pc = 32'h3008;
      in_instr = 32'h20000000 | in_pc;
      cycle();
      chk("bp_a_hold_pc", 128'(oa.f.pc), 128'h3000);
      chk("bp_a_hold_imm", 128'(oa.f.imm), 128'h3000);
      out_ready = 1'b1;
      #1;
      chk("bp_b_rdy_comb", 128'(ob.rdy), 128'd1);
      cycle();
      chk("bp_a_out1", 128'({oa.vld, oa.f.pc}), 128'({1'b1, 32'h3004}));
      cycle();
      chk("bp_a_out2", 128'({oa.vld, oa.f.pc}), 128'({1'b1, 32'h3008}));
      in_valid = 1'b0;
      cycle();
      chk("bp_a_drained", 128'(oa.vld), 128'd0);
      repeat (2) cycle();

      // streaming: one word per cycle, no bubbles
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         in_pc = 32'h7000 + 32'(i * 4);
         in_instr = rand_word();
         cycle();
         chk($sformatf("stream%0d_a", i), 128'({oa.vld, oa.f.pc}), 128'({1'b1, in_pc}));
         chk($sformatf("stream%0d_b", i), 128'({ob.vld, ob.f.pc}), 128'({1'b1, in_pc}));
      end
      in_valid = 1'b0;
      repeat (2) cycle();

      // flush while A is full with a word offered
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_pc = 32'h4000;
      in_instr = 32'h24000000 | in_pc;
      cycle();
      in_pc = 32'h4004;
      in_instr = 32'h24000000 | in_pc;
      cycle();
      flush = 1'b1;
      in_pc = 32'h5000;
      in_instr = 32'h24000000 | in_pc;
      cycle();
      flush = 1'b0;
      in_valid = 1'b0;
      chk("flush_a_vld", 128'(oa.vld), 128'd0);
      chk("flush_a_rdy", 128'(oa.rdy), 128'd1);
      chk("flush_b_vld", 128'(ob.vld), 128'd0);
      out_ready = 1'b1;
      repeat (3) cycle();

      // asynchronous reset between edges with two words held in A
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_pc = 32'h6100;
      in_instr = 32'h3C01F3D4;
      cycle();
      in_pc = 32'h6104;
      in_instr = 32'h1022FFFE;
      cycle();
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_reset_a", 128'(oa), 128'(z));
      chk("mid_reset_b", 128'(ob), 128'(z));
      qa.delete();
      qb.delete();
      #2;
      rst_n = 1'b1;
      out_ready = 1'b1;
      in_valid = 1'b1;
      in_pc = 32'h6000;
      in_instr = 32'h3422F3D4;
      cycle();
      chk("post_reset_a", 128'({oa.vld, oa.f.pc}), 128'({1'b1, 32'h6000}));
      chk("post_reset_b", 128'({ob.vld, ob.f.pc}), 128'({1'b1, 32'h6000}));
      in_valid = 1'b0;
      cycle();

      // randomized traffic against the queue model
      for (int i = 0; i < 600; i++) begin
         in_valid = $urandom_range(0, 3) != 0;
         out_ready = $urandom_range(0, 9) < 6;
         flush = $urandom_range(0, 19) == 0;
         in_pc = 32'h8000 + 32'(i * 4);
         in_instr = rand_word();
         cycle();
      end
      flush = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (3) cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
